// File: rtl/uart_tx_scheduler_if.sv
// Requester/UART bundle for the shared UART transmit scheduler.
// The requester and UART side is the master; the scheduler is the slave.
interface uart_tx_scheduler_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic              busy;
  logic [2:0]        owner;
  logic [31:0]       uart_data;
  logic              uart_send_req;
  logic              uart_irq;

  modport master (
    output req, req_data, uart_irq,
    input  ack, err, busy, owner, uart_data, uart_send_req
  );

  modport slave (
    input  req, req_data, uart_irq,
    output ack, err, busy, owner, uart_data, uart_send_req
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between NREQ requesters.
// One byte in flight at a time, with a watchdog on the UART completion interrupt.
module uart_tx_scheduler #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 16384,
  parameter int GAP     = 4
) (
  input  logic              clock,
  input  logic              Rst,
  uart_tx_scheduler_if.slave bus
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GPW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     owner_q, owner_d;
  logic [2:0]     rr_q, rr_d;
  logic [7:0]     data_q, data_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [GPW-1:0] gap_q, gap_d;
  logic           err_q, err_d;

  logic           grant_vld;
  logic [2:0]     grant_idx;
  logic [7:0]     grant_byte;
  logic           hi_vld;
  logic [2:0]     hi_idx, lo_idx;

  // Lowest set bit at or above rr_q wins; otherwise wrap to the lowest set bit.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.req[j]) begin
        lo_idx = 3'(j);
        if (3'(j) >= rr_q) begin
          hi_vld = 1'b1;
          hi_idx = 3'(j);
        end
      end
    end
    grant_vld = |bus.req;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    grant_byte = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_idx == 3'(j)) grant_byte = bus.req_data[8*j +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    data_d  = data_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          owner_d = grant_idx;
          data_d  = grant_byte;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        err_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion seen on the last watchdog cycle still counts as success.
        if (bus.uart_irq) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE: begin
        rr_d    = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
        gap_d   = '0;
        state_d = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_q == GPW'(GAP - 1)) state_d = S_IDLE;
        else                        gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  assign bus.ack           = (state_q == S_DONE) ? (NREQ'(1) << owner_q) : '0;
  assign bus.err           = (state_q == S_DONE) && err_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.owner         = owner_q;
  assign bus.uart_data     = {24'h0, data_q};
  assign bus.uart_send_req = (state_q == S_ISSUE);

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single `uart` transmitter between `NREQ` requesters, for example the CPU store path, a debug monitor and a trace unit. It arbitrates round-robin and latches the winner's byte. It then issues a one-cycle `send_req` pulse to the UART and waits for the UART `interrupt` (transmission done), with a watchdog timeout. Each requester gets a per-byte completion acknowledge. The block sits between the requesters and `uart` and owns the UART's `data`/`send_req` inputs.

## Interface
- `NREQ`, 3: number of requesters (2..8).
- `TIMEOUT`, 16384: max cycles to wait for `interrupt` after `send_req`. Default exceeds one 10-bit frame at the UART's baud divisor.
- `GAP`, 4: idle cycles enforced between consecutive transmissions (0 allowed).

- `clock`  in  1  system clock; all logic on rising edge.
- `Rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester request; level, held until matching `ack` bit.
- `req_data`  in  NREQ*8  byte of requester i at bits [8i+7:8i].
- `ack`  out  NREQ  one-cycle pulse to the served requester when its byte is done or aborted.
- `err`  out  1  one-cycle pulse coincident with `ack` when the byte timed out.
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  3  index of the requester currently being served; valid while `busy`.
- `uart_data`  out  32  to `uart.data`; bits [31:8] always 0.
- `uart_send_req`  out  1  to `uart.send_req`; one-cycle pulse.
- `uart_irq`  in  1  from `uart.interrupt`; high = transmission complete.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE, GAP.
- **IDLE:**
  - If any `req` bit is set, grant the first set bit at or after `rr_ptr`, searching upward and wrapping modulo NREQ.
  - On grant: latch that requester's byte into `uart_data[7:0]`, set `owner`, then go to ISSUE.
  - If no `req` bit is set, stay in IDLE.
- **ISSUE:** `uart_send_req`=1 for exactly one cycle; the watchdog counter is cleared; go to WAIT.
- **WAIT:**
  - The watchdog increments each cycle.
  - If `uart_irq`=1, go to DONE with no error.
  - If the watchdog reaches TIMEOUT-1 without `uart_irq`, go to DONE with `err` pending.
  - If both happen in the same cycle, `uart_irq` wins and no error is raised.
  - `uart_irq` is ignored in every state except WAIT.
- **DONE (one cycle):**
  - `ack[owner]`=1; `err`=1 if the timeout path was taken.
  - `rr_ptr` ← (owner+1) mod NREQ.
  - Go to GAP if GAP>0, otherwise go to IDLE.
- **GAP:** count GAP cycles, then go to IDLE.
- **Requester rules:**
  - A requester may not change `req_data` while `req` is high.
  - A requester drops `req` at the latest the cycle after `ack`.
  - If a requester deasserts `req` after it has been granted, that does not abort the transfer; the transfer completes and is acknowledged normally.
- `uart_data` holds the latched byte from grant until the next grant. It does not change during WAIT.
- **Reset:** any state → IDLE immediately.
  - An in-flight byte is dropped: no `ack` or `err` is issued for it.
  - `rr_ptr`=0.

## Timing
- **Reset values:** `ack`=0, `err`=0, `busy`=0, `owner`=0, `uart_data`=0, `uart_send_req`=0.
- **Request to send:** `req` sampled high in IDLE at edge k → `uart_send_req` high during cycle k+1. `uart_data` is already valid in cycle k+1, i.e. data is stable when the UART samples `send_req`.
- **Completion:** `uart_irq` sampled high in WAIT at edge m → `ack` high during cycle m+1.
- **Next grant:** earliest is edge m+2+GAP.
- **`busy`:** high from cycle k+1 through the final GAP cycle.
- **Timeout:** `ack`+`err` appear TIMEOUT+1 cycles after the `uart_send_req` pulse.
- **Throughput:** at most one byte in flight; no queuing inside the block.

## Test plan
- **Single requester:** NREQ=3, GAP=4. Assert `req[1]` with byte 8'h0A. Expect:
  - `uart_send_req` pulses once with `uart_data`=32'h0000000A.
  - A modeled `uart_irq` 500 cycles later → `ack`=3'b010 one cycle after, `err`=0.
  - `busy` falls 5 cycles after `ack`.
- **Round-robin:** hold `req`=3'b111 with bytes 8'h11/8'h22/8'h33. Expect service order 0,1,2,0. Re-raise `req[0]` after its ack → it is served only after 1 and 2.
- **Timeout:** TIMEOUT=64, `uart_irq` never asserted. Expect `ack[owner]`+`err` high together exactly 65 cycles after `uart_send_req`; the next requester is then served normally.
- **Simultaneous irq and timeout:** `uart_irq` rises on the final watchdog cycle. Expect `ack` with `err`=0.
- **Reset mid-WAIT:** assert `Rst` asynchronously between clock edges. Expect all outputs 0 immediately and no `ack` for the dropped byte. After release with `req`=3'b100, requester 2 is granted.
- **Stray irq:** pulse `uart_irq` in IDLE and in GAP. Expect no `ack`, and no state change beyond normal GAP timing.
